// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared states, opcode classes and instruction field layout
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_ADD       = 6'd0;
  localparam logic [5:0] OP_FIRST_CMP = 6'd8;
  localparam logic [5:0] OP_LAST_CMP  = 6'd13;
  localparam logic [5:0] OP_FIRST_NOP = 6'd16;
  localparam logic [5:0] OP_LAST_NOP  = 6'd62;
  localparam logic [5:0] OP_HALT      = 6'd63;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 18;
  localparam int HL_BIT  = 17;
  localparam int VAL_MSB = 15;
  localparam int VAL_LSB = 0;

  // Opcodes 0..7 share the ADD group's upper bits, so one compare selects them.
  function automatic logic is_wb_class(input logic [5:0] op);
    return op[5:3] == OP_ADD[5:3];
  endfunction

  function automatic logic is_flag_class(input logic [5:0] op);
    return (op >= OP_FIRST_CMP) && (op <= OP_LAST_CMP);
  endfunction

  function automatic logic is_nop_class(input logic [5:0] op);
    return (op >= OP_FIRST_NOP) && (op <= OP_LAST_NOP);
  endfunction

endpackage

// File: rtl/fetch_sequencer_instr_decode.sv
// rtl/fetch_sequencer_instr_decode.sv - combinational split of an instruction word into fields and classes
module instr_decode
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] word,
  output logic [5:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic        hl,
  output logic [15:0] imm,
  output logic        wb_class,
  output logic        flag_class,
  output logic        nop_class
);

  logic unused_rsvd;

  assign opcode     = word[OPC_MSB:OPC_LSB];
  assign rd         = word[RD_MSB:RD_LSB];
  assign rs         = word[RS_MSB:RS_LSB];
  assign hl         = word[HL_BIT];
  assign imm        = word[VAL_MSB:VAL_LSB];
  assign unused_rsvd = word[16];

  assign wb_class   = is_wb_class(opcode);
  assign flag_class = is_flag_class(opcode);
  assign nop_class  = is_nop_class(opcode);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - four-phase fetch/decode/execute/write-back sequencer with halt
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = OP_HALT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [5:0]  instr,
  output logic [3:0]  rd_sel,
  output logic [3:0]  rs_sel,
  output logic        highlow,
  output logic [15:0] value,
  output logic        alu_en,
  output logic        wb_en,
  input  logic        addrch,
  input  logic [31:0] naddr,
  input  logic        f3,
  output logic        flag,
  output logic [31:0] pc,
  output logic        halted
);

  state_t      state;
  logic [31:0] ir;
  logic        br_taken;
  logic [31:0] br_target;
  logic        f3_q;
  logic        wb_class;
  logic        flag_class;
  logic        nop_class;

  instr_decode u_decode (
    .word       (ir),
    .opcode     (instr),
    .rd         (rd_sel),
    .rs         (rs_sel),
    .hl         (highlow),
    .imm        (value),
    .wb_class   (wb_class),
    .flag_class (flag_class),
    .nop_class  (nop_class)
  );

  assign mem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      flag      <= 1'b0;
      ir        <= 32'd0;
      mem_req   <= 1'b0;
      alu_en    <= 1'b0;
      wb_en     <= 1'b0;
      halted    <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= 32'd0;
      f3_q      <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      wb_en  <= 1'b0;
      case (state)
        // An ack only counts once the request is visibly high, so a stale ack
        // in the first cycle out of reset is dropped.
        S_FETCH: begin
          if (mem_req && mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (instr == HALT_OP) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            alu_en <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          br_taken  <= addrch;
          br_target <= naddr;
          f3_q      <= f3;
          wb_en     <= wb_class;
          state     <= S_WB;
        end
        S_WB: begin
          if (br_taken && !nop_class) begin
            pc <= br_target;
          end else begin
            pc <= pc + 32'd1;
          end
          if (flag_class) begin
            flag <= f3_q;
          end
          mem_req <= 1'b1;
          state   <= S_FETCH;
        end
        S_HALT: begin
          mem_req <= 1'b0;
          state   <= S_HALT;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, program counter value loaded on reset.
REQ-002 Parameter HALT_OP, default 6'd63, opcode that stops the sequencer.
REQ-003 The block SHALL use one clock and a synchronous active-high reset: clock input 1, rising-edge clock; reset input 1, synchronous, active-high.
REQ-004 mem_req  output  1  instruction fetch request.
REQ-005 mem_addr  output  32  word address of the fetch, equal to pc.
REQ-006 mem_ack  input  1  fetch data valid this cycle.
REQ-007 mem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  6  decoded opcode, from word[31:26].
REQ-009 rd_sel  output  4  destination/A register index, from word[25:22].
REQ-010 rs_sel  output  4  B register index, from word[21:18].
REQ-011 highlow  output  1  load-half select, from word[17].
REQ-012 value  output  16  immediate, from word[15:0].
REQ-013 alu_en  output  1  one-cycle ALU execute strobe.
REQ-014 wb_en  output  1  one-cycle register write-back strobe.
REQ-015 addrch  input  1  branch-taken from ALU.
REQ-016 naddr  input  32  branch target from ALU.
REQ-017 f3  input  1  ALU compare result.
REQ-018 flag  output  1  registered compare flag, fed back to ALU F1.
REQ-019 pc  output  32  current program counter.
REQ-020 halted  output  1  high while in HALT.

Function
REQ-021 The FSM SHALL have states FETCH, DECODE, EXEC, WB, HALT.
REQ-022 FETCH: mem_req=1 and mem_addr=pc; on mem_ack=1, latch mem_rdata into the instruction register and go to DECODE; otherwise stay in FETCH with mem_req held high.
REQ-023 mem_ack is accepted in the same cycle mem_req first rises; mem_ack outside FETCH SHALL be ignored.
REQ-024 DECODE: instr/rd_sel/rs_sel/highlow/value driven from the latched word, unchanged until the next DECODE; if opcode==HALT_OP, go to HALT, else to EXEC.
REQ-025 EXEC: alu_en=1 for exactly one cycle; sample addrch, naddr and f3 at the end of this cycle; go to WB.
REQ-026 WB: wb_en=1 for one cycle if opcode is 0..7, else 0; go to FETCH.
REQ-027 In WB, pc SHALL load the sampled naddr if the sampled addrch=1, else pc+1, with modulo-2^32 wrap (32'hFFFF_FFFF -> 0).
REQ-028 In WB, flag SHALL take the sampled f3 for opcodes 8..13 and hold otherwise.
REQ-029 Opcodes 16..62 SHALL execute as no-ops: alu_en still pulses, wb_en=0, and pc=pc+1 regardless of addrch.
REQ-030 HALT: all strobes and mem_req are 0 and halted=1; it is left only by reset.
REQ-031 With zero-wait memory, an instruction SHALL take exactly 4 cycles (FETCH, DECODE, EXEC, WB).

Reset
REQ-032 On reset: state=FETCH, pc=RESET_PC, flag=0, instruction register=0, mem_req=0, alu_en=0, wb_en=0, halted=0.
REQ-033 Reset asserted mid-fetch or mid-execute SHALL abort the operation: no strobe fires in the cycle after reset, and a pending mem_ack is discarded.
REQ-034 mem_req SHALL rise in the first cycle after reset deasserts.

Structure
REQ-035 A shared package SHALL hold the state enum, the opcode constants (ADD=0 .. HALT=63), and the instruction field bit positions.
REQ-036 The decode logic SHALL be a combinational sub-module, instr_decode (word in; fields, wb-class and flag-class out); the FSM, pc and flag registers stay in the top module.

Verification
REQ-037 Zero-wait memory: words 0x00400000 then 0x04400000 -> alu_en pulses 4 cycles apart; wb_en=1 for both; pc steps 0->1->2.
REQ-038 mem_ack delayed 3 cycles -> mem_req held high with mem_addr stable for 4 cycles; exactly one DECODE follows.
REQ-039 Opcode 14 with addrch=1, naddr=0x20 -> pc=0x20 after WB; next mem_addr=0x20.
REQ-040 pc=0xFFFFFFFF running a no-op (opcode 20) -> pc wraps to 0; wb_en=0.
REQ-041 Opcode 8 with f3=1 -> flag=1 after WB; a following opcode 0 leaves flag at 1.
REQ-042 Opcode 63 -> halted=1 and mem_req=0 indefinitely; reset mid-HALT -> pc=RESET_PC and a fetch resumes the next cycle.
